// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into instruction memory writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit data checksum byte.
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             imem_wr_en,
    output logic [31:0]      imem_wr_addr,
    output logic [31:0]      imem_wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   words_loaded_q, words_loaded_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [15:0]        count_q, count_d;
    logic [23:0]        asm_q, asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               accept;
    logic [15:0]        cnt_full;
    logic [31:0]        word_full;
    logic               last_word;

    assign accept    = in_valid && in_ready_q;
    assign cnt_full  = {count_q[15:8], in_data};
    assign word_full = {asm_q, in_data};
    // words_loaded has already caught up with the previous word here
    assign last_word = (16'(words_loaded_q) + 16'd1) == count_q;

    always_comb begin
        state_d        = state_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;
        byte_idx_d     = byte_idx_q;
        count_d        = count_q;
        asm_d          = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif

        if (wr_en_q) begin
            words_loaded_d = words_loaded_q + CNT_W'(1);
        end

        unique case (state_q)
            S_CNT_HI: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d = 8'h00;
`endif
                if (accept) begin
                    count_d[15:8] = in_data;
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    byte_idx_d   = 2'd0;
                    if (cnt_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d    = S_CSUM;
`else
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
`endif
                    end else if (32'(cnt_full) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d      = word_full[23:0];
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q + in_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word_full;
                        wr_addr_d = BASE_ADDR
                                  + (32'(words_loaded_q) << 2);
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                // done follows the final strobe by one edge
                if (wr_en_q) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end
            S_ERR: begin
            end
            default: begin
                state_d = S_ERR;
                error_d = 1'b1;
            end
        endcase

        if (start && (state_q == S_DONE || state_q == S_ERR)) begin
            state_d        = S_CNT_HI;
            done_d         = 1'b0;
            error_d        = 1'b0;
            cpu_hold_d     = 1'b1;
            words_loaded_d = '0;
            wr_addr_d      = BASE_ADDR;
            byte_idx_d     = 2'd0;
        end

        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_CNT_HI;
            in_ready_q     <= 1'b1;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= BASE_ADDR;
            wr_data_q      <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            byte_idx_q     <= '0;
            count_q        <= '0;
            asm_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
            byte_idx_q     <= byte_idx_d;
            count_q        <= count_d;
            asm_q          <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a queue-based image model.
// Honours IMEM_LOADER_CHECKSUM_EN by appending the expected checksum byte.
module tb_imem_loader;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             imem_wr_en;
    logic [31:0]      imem_wr_addr;
    logic [31:0]      imem_wr_data;
    logic             cpu_hold;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    imem_loader #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] wr_q[$];
    logic [7:0]  stream[$];
    logic [31:0] img_words[$];

    // Writes are captured before the edge updates the DUT
    always @(posedge clk) begin
        if (reset && imem_wr_en)
            wr_q.push_back({imem_wr_addr, imem_wr_data});
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data = b;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            failures++;
            $display("FAIL send_timeout got in_ready=%0b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic send_stream(input int gap);
        foreach (stream[i]) begin
            send_byte(stream[i]);
            if (gap >= 0) repeat (gap) @(negedge clk);
            else repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Stream image from img_words: count, big-endian words, optional sum
    task automatic build_image();
        logic [7:0] sum;
        logic [31:0] w;
        int n;
        n = img_words.size();
        sum = 8'h00;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        foreach (img_words[i]) begin
            w = img_words[i];
            for (int k = 3; k >= 0; k--) begin
                stream.push_back(w[8*k +: 8]);
                sum = sum + w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(sum);
`endif
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done === 1'b1 || error === 1'b1) && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_writes(input string tag);
        checks++;
        if (wr_q.size() != img_words.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d",
                     tag, wr_q.size(), img_words.size());
        end else begin
            foreach (img_words[i]) begin
                checks++;
                if (wr_q[i] !== {BASE + 32'(4 * i), img_words[i]}) begin
                    failures++;
                    $display("FAIL %s_wr%0d got=%h exp=%h", tag, i,
                             wr_q[i], {BASE + 32'(4 * i), img_words[i]});
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        @(negedge clk);
        checks += 8;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        if (imem_wr_en !== 1'b0) begin
            failures++; $display("FAIL rst_wr_en got=%b exp=0", imem_wr_en);
        end
        if (imem_wr_addr !== BASE) begin
            failures++; $display("FAIL rst_addr got=%h exp=%h", imem_wr_addr, BASE);
        end
        if (imem_wr_data !== 32'h0) begin
            failures++; $display("FAIL rst_data got=%h exp=0", imem_wr_data);
        end
        if (cpu_hold !== 1'b1) begin
            failures++; $display("FAIL rst_hold got=%b exp=1", cpu_hold);
        end
        if (done !== 1'b0) begin
            failures++; $display("FAIL rst_done got=%b exp=0", done);
        end
        if (error !== 1'b0) begin
            failures++; $display("FAIL rst_error got=%b exp=0", error);
        end
        if (words_loaded !== '0) begin
            failures++; $display("FAIL rst_words got=%0d exp=0", words_loaded);
        end
        reset = 1'b1;
        @(negedge clk);
        wr_q.delete();
    endtask

    task automatic test_basic();
        do_reset();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'hC6);
`endif
        img_words = '{32'h2008_0005, 32'h8C09_0004};
        send_stream(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checks += 3;
        if (imem_wr_en !== 1'b1 || imem_wr_data !== 32'h8C09_0004) begin
            failures++;
            $display("FAIL basic_strobe got=%b/%h exp=1/8c090004",
                     imem_wr_en, imem_wr_data);
        end
        if (imem_wr_addr !== BASE + 32'h4) begin
            failures++;
            $display("FAIL basic_addr got=%h exp=%h", imem_wr_addr, BASE + 32'h4);
        end
        if (done !== 1'b0) begin
            failures++; $display("FAIL basic_early_done got=%b exp=0", done);
        end
        @(negedge clk);
`endif
        checks += 3;
        if (done !== 1'b1) begin
            failures++; $display("FAIL basic_done got=%b exp=1", done);
        end
        if (cpu_hold !== 1'b0) begin
            failures++; $display("FAIL basic_hold got=%b exp=0", cpu_hold);
        end
        if (words_loaded !== CNT_W'(2)) begin
            failures++; $display("FAIL basic_words got=%0d exp=2", words_loaded);
        end
        repeat (2) @(negedge clk);
        check_writes("basic");
    endtask

    task automatic test_gaps();
        do_reset();
        img_words = '{32'h2008_0005, 32'h8C09_0004};
        build_image();
        send_stream(3);
        wait_end();
        checks += 2;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL gaps_done got=%b/%b exp=1/0", done, error);
        end
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL gaps_ready got=%b exp=0", in_ready);
        end
        check_writes("gaps");
    endtask

    task automatic test_oversize();
        do_reset();
        stream = '{8'h04, 8'h01};
        send_stream(0);
        checks += 4;
        if (error !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ovr_error got=%b/%b exp=1/0", error, done);
        end
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL ovr_ready got=%b exp=0", in_ready);
        end
        if (cpu_hold !== 1'b1) begin
            failures++; $display("FAIL ovr_hold got=%b exp=1", cpu_hold);
        end
        repeat (3) @(negedge clk);
        if (wr_q.size() != 0) begin
            failures++; $display("FAIL ovr_writes got=%0d exp=0", wr_q.size());
        end
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        checks += 3;
        if (error !== 1'b0) begin
            failures++; $display("FAIL ovr_rearm_err got=%b exp=0", error);
        end
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL ovr_rearm_ready got=%b exp=1", in_ready);
        end
        if (cpu_hold !== 1'b1) begin
            failures++; $display("FAIL ovr_rearm_hold got=%b exp=1", cpu_hold);
        end
        img_words = '{32'h1122_3344};
        build_image();
        send_stream(0);
        wait_end();
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL ovr_reload got=%b/%b exp=1/0", done, error);
        end
        check_writes("ovr");
    endtask

    task automatic test_zero();
        do_reset();
        stream = '{8'h00, 8'h00};
        send_stream(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_csum_wait got=%b/%b exp=0/1", done, in_ready);
        end
        stream = '{8'h00};
        send_stream(0);
`endif
        wait_end();
        checks += 3;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got=%b/%b exp=1/0", done, error);
        end
        if (cpu_hold !== 1'b0) begin
            failures++; $display("FAIL zero_hold got=%b exp=0", cpu_hold);
        end
        if (wr_q.size() != 0 || words_loaded !== '0) begin
            failures++;
            $display("FAIL zero_writes got=%0d/%0d exp=0/0",
                     wr_q.size(), words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream(0);
        checks++;
        if (imem_wr_en !== 1'b1) begin
            failures++; $display("FAIL mid_pending got=%b exp=1", imem_wr_en);
        end
        reset = 1'b0;
        #1;
        checks += 2;
        if (imem_wr_en !== 1'b0) begin
            failures++; $display("FAIL mid_drop got=%b exp=0", imem_wr_en);
        end
        if (words_loaded !== '0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL mid_rstvals got=%0d/%b exp=0/1", words_loaded, cpu_hold);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_q.delete();
        stream = '{8'h00, 8'h02, 8'h11, 8'h22};
        send_stream(0);
        do_reset();
        img_words = '{32'hDEAD_BEEF};
        build_image();
        send_stream(0);
        wait_end();
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("FAIL mid_done got=%b exp=1", done);
        end
        check_writes("mid");
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            img_words.delete();
            for (int i = 0; i < n; i++) img_words.push_back($urandom);
            build_image();
            send_stream(-1);
            wait_end();
            checks += 2;
            if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
                failures++;
                $display("FAIL rnd%0d_status got=%b%b%b exp=100",
                         it, done, error, cpu_hold);
            end
            if (words_loaded !== CNT_W'(n)) begin
                failures++;
                $display("FAIL rnd%0d_words got=%0d exp=%0d", it, words_loaded, n);
            end
            check_writes("rnd");
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b0 || words_loaded !== '0 || cpu_hold !== 1'b1) begin
                failures++;
                $display("FAIL rnd%0d_rearm got=%b/%0d/%b exp=0/0/1",
                         it, done, words_loaded, cpu_hold);
            end
            wr_q.delete();
        end
    endtask

    task automatic test_full_depth();
        do_reset();
        img_words.delete();
        for (int i = 0; i < DEPTH; i++) img_words.push_back($urandom);
        build_image();
        send_stream(0);
        wait_end();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== CNT_W'(DEPTH)) begin
            failures++;
            $display("FAIL full_status got=%b/%b/%0d exp=1/0/%0d",
                     done, error, words_loaded, DEPTH);
        end
        check_writes("full");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        img_words = '{32'h0102_0304};
        stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        send_stream(0);
        wait_end();
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL csum_ok got=%b/%b exp=1/0", done, error);
        end
        check_writes("csum_ok");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_q.delete();
        stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        send_stream(0);
        wait_end();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL csum_bad got=%b/%b/%b exp=1/0/1",
                     error, done, cpu_hold);
        end
        check_writes("csum_bad");
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_oversize();
        test_zero();
        test_reset_mid();
        test_random();
        test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory.
- Receives a byte stream from a host over a valid/ready link and assembles big-endian 32-bit instruction words.
- Issues single-cycle write strobes into the instruction memory array, starting at BASE_ADDR.
- Holds the pipeline via cpu_hold until the image is fully loaded.

Parameters:
DEPTH, 1024, instruction memory size in 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word aligned.
CNT_W, $clog2(DEPTH)+1, width of the word counters.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
in_valid  input  1  host byte valid.
in_data  input  8  host byte.
in_ready  output  1  loader can accept a byte this cycle.
imem_wr_en  output  1  one-cycle instruction memory write strobe.
imem_wr_addr  output  32  byte address of the write, word aligned.
imem_wr_data  output  32  instruction word to write.
cpu_hold  output  1  high while loading; keeps the pipeline in reset.
done  output  1  image loaded successfully; sticky.
error  output  1  protocol error; sticky.
words_loaded  output  CNT_W  number of words written so far.

Behaviour:
- Reset values (reset=0): state=CNT_HI, in_ready=1, imem_wr_en=0, imem_wr_addr=BASE_ADDR, imem_wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0, byte index=0.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- Stream format: count high byte, count low byte (16-bit word count N), then N words of 4 bytes each, MSB first.
- State CNT_HI: in_ready=1. Accept byte into N[15:8]; go to CNT_LO.
- State CNT_LO: in_ready=1. Accept byte into N[7:0]. Then:
  - N==0: go to DONE.
  - N>DEPTH: go to ERR.
  - Otherwise: go to DATA.
- State DATA: in_ready=1 every cycle; the loader sustains one byte per cycle.
  - Bytes shift into an assembly register; a 2-bit byte index counts 0..3.
  - On accepting byte 3, the next cycle presents imem_wr_en=1 for exactly one cycle, with imem_wr_data = assembled word and imem_wr_addr = BASE_ADDR + 4*words_loaded (pre-increment value).
  - words_loaded increments on the edge that ends the strobe cycle.
  - Address arithmetic is 32-bit modulo; no wrap occurs inside a legal image, since N<=DEPTH.
  - After the N-th word is accepted, go to CSUM if IMEM_LOADER_CHECKSUM_EN is defined, otherwise to DONE. The final write strobe still occurs in the first cycle of the new state.
- State DONE: in_ready=0; done=1, asserted the edge after the final write strobe (or the edge after CNT_LO when N==0); cpu_hold=0 on that same edge.
- State ERR: in_ready=0, error=1, cpu_hold stays 1. Words already written are not rolled back.
- start in DONE or ERR:
  - Next edge: state=CNT_HI, done=0, error=0, cpu_hold=1, words_loaded=0, imem_wr_addr=BASE_ADDR.
  - start is ignored in all other states.
  - A byte presented in the same cycle as start is not accepted, because in_ready=0.
- in_valid gaps mid-word or mid-count: state and partial word are held indefinitely; there is no timeout.
- Reset mid-load: immediate return to reset values. A pending write strobe is dropped.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of every data byte, count bytes excluded, is cleared in CNT_HI.
  - After the N-th word, state CSUM sets in_ready=1 and accepts one byte.
  - Match: DONE on the next edge. Mismatch: ERR on the next edge.
  - With N==0, CSUM is still entered and expects 8'h00.
- Not defined: no CSUM state. The image ends after the N-th word.

Test Plan:
- Stream 00 02 20 08 00 05 8C 09 00 04, in_valid continuous -> writes: addr 0x0 data 0x20080005, then addr 0x4 data 0x8C090004; done=1 and cpu_hold=0 one cycle after the second strobe; words_loaded=2.
- Same stream with in_valid low for 3 cycles after every byte -> identical writes; no extra or duplicated strobes.
- Stream 04 01 (N=1025) -> error=1 after the second byte, no write strobes, cpu_hold=1; then start pulse -> error=0, in_ready=1, cpu_hold=1.
- Stream 00 00 -> done=1 with zero strobes (no macro); with the macro, the extra byte 00 is required before done.
- reset=0 asserted after 2 bytes of the first word, then released, then a fresh 00 01 DE AD BE EF -> one write, addr 0x0 data 0xDEADBEEF.
- Macro defined: 00 01 01 02 03 04 0A -> done=1; same stream with checksum 0B -> error=1, yet the word 0x01020304 is still written to addr 0x0.
